// File: rtl/ifu_fetch_queue.sv
// In-order instruction fetch queue between redirect/icache sources and the IDU handshake.
// Optional macro IFU_BYPASS_EN forwards a response straight to the IDU when the queue holds nothing filled.
module ifu_fetch_queue #(
   parameter int unsigned       ADDR_W   = 64,
   parameter int unsigned       MEM_AW   = 32,
   parameter int unsigned       INST_W   = 32,
   parameter int unsigned       LINE_W   = 64,
   parameter int unsigned       DEPTH    = 4,
   parameter logic [ADDR_W-1:0] RESET_PC = 64'h8000_0000
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              intr_valid_i,
   input  logic [ADDR_W-1:0] intr_pc_i,
   input  logic              jump_valid_i,
   input  logic [ADDR_W-1:0] jump_pc_i,
   input  logic              halt_i,
   output logic              icache_req_o,
   output logic [MEM_AW-1:0] icache_addr_o,
   input  logic              icache_ready_i,
   input  logic              icache_rvalid_i,
   input  logic [LINE_W-1:0] icache_rdata_i,
   output logic              out_valid_o,
   input  logic              out_ready_i,
   output logic [INST_W-1:0] out_inst_o,
   output logic [ADDR_W-1:0] out_pc_o
);

   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CNT_W = $clog2(DEPTH + 1);
   localparam int unsigned SUM_W = CNT_W + 1;

   logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
   logic [ADDR_W-1:0] pc_q   [DEPTH];
   logic [INST_W-1:0] inst_q [DEPTH];
   logic [DEPTH-1:0]  filled_q, filled_d;
   logic [PTR_W-1:0]  head_q, head_d, tail_q, tail_d, fill_q, fill_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d, unf_q, unf_d, drop_q, drop_d;
   logic              halted_q, halted_d;

   logic              redir, accept, fill_en, fill_store, pop, byp_pop, q_valid;
   logic [ADDR_W-1:0] tgt, issue_pc;
   logic [PTR_W-1:0]  alloc_idx;
   logic [INST_W-1:0] resp_inst;

   // Request, response, output and pointer bookkeeping
   always_comb begin
      redir      = intr_valid_i | jump_valid_i;
      tgt        = (intr_valid_i ? intr_pc_i : jump_pc_i) & ~ADDR_W'(3);
      issue_pc   = redir ? tgt : fetch_pc_q;
      icache_addr_o = MEM_AW'(issue_pc);
      icache_req_o  = !rst_i & !halted_q & !halt_i & (cnt_q < CNT_W'(DEPTH))
                      & ((SUM_W'(unf_q) + SUM_W'(drop_q)) < SUM_W'(DEPTH));
      accept     = icache_req_o & icache_ready_i;
      alloc_idx  = redir ? '0 : tail_q;
      fill_en    = icache_rvalid_i & (drop_q == '0) & !redir;
      resp_inst  = pc_q[fill_q][2] ? icache_rdata_i[2*INST_W-1:INST_W]
                                   : icache_rdata_i[INST_W-1:0];
      q_valid    = filled_q[head_q] & !redir & !halted_q;
      out_pc_o   = pc_q[head_q];
`ifdef IFU_BYPASS_EN
      if (fill_en & !filled_q[head_q] & (cnt_q != '0) & (fill_q == head_q)
          & !redir & !halted_q) begin
         out_valid_o = 1'b1;
         out_inst_o  = resp_inst;
         byp_pop     = out_ready_i;
      end else begin
         out_valid_o = q_valid;
         out_inst_o  = inst_q[head_q];
         byp_pop     = 1'b0;
      end
`else
      out_valid_o = q_valid;
      out_inst_o  = inst_q[head_q];
      byp_pop     = 1'b0;
`endif
      pop        = out_valid_o & out_ready_i;
      fill_store = fill_en & !byp_pop;

      halted_d   = halted_q | halt_i;
      fetch_pc_d = accept ? issue_pc + ADDR_W'(4) : (redir ? tgt : fetch_pc_q);
      filled_d   = filled_q;
      if (redir) begin
         // Flush: every unfilled slot becomes a response to discard.
         cnt_d    = CNT_W'(accept);
         unf_d    = CNT_W'(accept);
         drop_d   = CNT_W'(SUM_W'(drop_q) + SUM_W'(unf_q) - SUM_W'(icache_rvalid_i));
         head_d   = '0;
         fill_d   = '0;
         tail_d   = PTR_W'(accept);
         filled_d = '0;
      end else begin
         cnt_d  = cnt_q + CNT_W'(accept) - CNT_W'(pop);
         unf_d  = unf_q + CNT_W'(accept) - CNT_W'(fill_en);
         drop_d = (icache_rvalid_i && drop_q != '0) ? drop_q - CNT_W'(1) : drop_q;
         head_d = head_q + PTR_W'(pop);
         tail_d = tail_q + PTR_W'(accept);
         fill_d = fill_q + PTR_W'(fill_en);
         if (pop && !byp_pop) filled_d[head_q] = 1'b0;
         if (fill_store)      filled_d[fill_q] = 1'b1;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         fetch_pc_q <= RESET_PC;
         filled_q   <= '0;
         head_q     <= '0;
         tail_q     <= '0;
         fill_q     <= '0;
         cnt_q      <= '0;
         unf_q      <= '0;
         drop_q     <= '0;
         halted_q   <= 1'b0;
         for (int i = 0; i < DEPTH; i++) begin
            pc_q[i]   <= '0;
            inst_q[i] <= '0;
         end
      end else begin
         fetch_pc_q <= fetch_pc_d;
         filled_q   <= filled_d;
         head_q     <= head_d;
         tail_q     <= tail_d;
         fill_q     <= fill_d;
         cnt_q      <= cnt_d;
         unf_q      <= unf_d;
         drop_q     <= drop_d;
         halted_q   <= halted_d;
         if (accept)     pc_q[alloc_idx] <= issue_pc;
         if (fill_store) inst_q[fill_q]  <= resp_inst;
      end
   end

endmodule

// File: doc/ifu_fetch_queue.md
# ifu_fetch_queue

Parametrised instruction-fetch front end that replaces the single-slot fetch register with a DEPTH-entry in-order fetch queue. It sits between the redirect sources (EX jump, interrupt) and the icache request/response channel on one side, and the IDU valid/ready handshake on the other. It keeps up to DEPTH fetches in flight, squashes stale responses after a redirect, and supports a sticky ebreak halt.

## Interface

- ADDR_W, 64: PC width.
- MEM_AW, 32: icache address width; low MEM_AW bits of the PC.
- INST_W, 32: instruction width.
- LINE_W, 64: icache response width; must be 2*INST_W.
- DEPTH, 4: queue entries and in-flight bound; power of 2, at least 2.
- RESET_PC, 64'h80000000: first fetch address.

- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- intr_valid  in  1  interrupt redirect.
- intr_pc  in  ADDR_W  interrupt target.
- jump_valid  in  1  branch/jump redirect from EX.
- jump_pc  in  ADDR_W  jump target.
- halt  in  1  ebreak; sets sticky halt.
- icache_req  out  1  fetch request valid.
- icache_addr  out  MEM_AW  fetch address; bits [1:0] are always 0.
- icache_ready  in  1  cache accepts the request.
- icache_rvalid  in  1  response valid; responses arrive in request order.
- icache_rdata  in  LINE_W  response line.
- out_valid  out  1  instruction to IDU valid.
- out_ready  in  1  IDU ready.
- out_inst  out  INST_W  instruction.
- out_pc  out  ADDR_W  PC of out_inst.

## Operation

- State:
  - fetch_pc, reset to RESET_PC.
  - DEPTH entries, each holding {pc, inst, filled}.
  - Pointers: head, tail, fill.
  - cnt: allocated entries.
  - drop_cnt: 0..DEPTH.
  - halted flag.
- Redirect:
  - redir = intr_valid | jump_valid.
  - Target is intr_pc if intr_valid, else jump_pc; bits [1:0] are forced to 0.
  - Interrupt wins when both are asserted.
- Request:
  - icache_req = !halted & !halt & (cnt < DEPTH) & (cnt_unfilled + drop_cnt < DEPTH).
  - icache_addr is the redirect target when redir, else fetch_pc.
  - On accept (icache_req & icache_ready): allocate the tail entry with that PC; fetch_pc <= issued PC + 4.
  - On redir without accept: fetch_pc <= target.
- Response:
  - If drop_cnt > 0, decrement drop_cnt and discard the data.
  - Otherwise fill the fill-pointer entry. inst = pc[2] ? rdata[63:32] : rdata[31:0].
- Output:
  - out_valid = head entry filled & !redir & !halted.
  - Handshake pops the head.
- Flush on redir:
  - Clear all entries (cnt = 0).
  - drop_cnt <= drop_cnt + cnt_unfilled - (icache_rvalid ? 1 : 0).
  - A request accepted in the redir cycle uses the target address and is live (allocated after the flush).
  - A response in the redir cycle consumes an outstanding slot: it is counted out of drop_cnt, never filled.
- Halt: halt sets halted, which clears only on reset. While halted, no requests are issued and responses are still counted and discarded.
- Width rules: PC arithmetic is modulo 2^ADDR_W; icache_addr is truncated to MEM_AW.

## Timing

- Reset values:
  - icache_req = 0 while rst is asserted.
  - out_valid = 0, out_inst = 0, out_pc = 0.
  - fetch_pc = RESET_PC, drop_cnt = 0, halted = 0.
- The first request, at RESET_PC, asserts the first cycle after rst deasserts.
- Latency: a response in cycle N gives out_valid in cycle N+1 (N with IFU_BYPASS_EN).
- Throughput: one request and one instruction per cycle sustained when icache_ready and out_ready are held high.
- Full queue: icache_req drops the same cycle cnt reaches DEPTH. A pop and an accept in the same cycle keep cnt unchanged.
- redir masks out_valid combinationally in the same cycle. No IDU handshake completes in a redir cycle.
- Reset mid-operation clears all entries and drop_cnt. The cache is reset by the same rst, so no stale responses arrive.

## Configuration

- IFU_BYPASS_EN:
  - Defined: when the queue has no filled entry and the head entry is the one being filled this cycle, out_valid/out_inst come combinationally from icache_rdata. If out_ready is high the entry is popped without being stored.
  - Undefined: out_* are driven only from queue entries (registered path, one-cycle latency).

## Test plan

- Reset release, icache_ready=1 and 1-cycle responses, out_ready=1: addresses 0x80000000, 0x80000004, 0x80000008… Each out_inst is the correct half (pc[2] selects rdata[63:32]).
- out_ready=0 with DEPTH=4: exactly 4 requests are issued, then icache_req=0. Raising out_ready yields the 4 instructions in order, then requests resume.
- Redirect drop:
  - Stimulus: 3 requests in flight, then jump_valid with jump_pc=0x80001002.
  - Required: the issued address is 0x80001000. The next 3 responses are discarded. The first out_pc is 0x80001000.
- intr_valid and jump_valid in the same cycle (intr_pc=0x80002000, jump_pc=0x80003000): the fetch goes to 0x80002000, and out_valid is 0 in that cycle.
- halt pulse: icache_req and out_valid stay 0 until rst. In-flight responses are absorbed without error.
- Bypass timing: with IFU_BYPASS_EN, an empty queue and a response in cycle N give out_valid in cycle N. Without the macro, out_valid comes in cycle N+1.
